if_id_elastic: RTL and testbench
================================

Name: if_id_elastic

Overview:
- Parametrised successor to the IF/ID pipeline register.
- Sits between fetch and decode and carries {Instr, Addr} pairs.
- Adds a valid/ready handshake on both sides, a 2-entry skid buffer so upstream can run at full rate under downstream backpressure, and configurable widths and bubble value.
- Retains hold (stall) and Flush (branch/jump squash) controls.

Parameters:
- INSTR_W, 32, instruction field width in bits.
- ADDR_W, 32, address field width in bits.
- BUBBLE_INSTR, 0 (INSTR_W bits), value driven on out_Instr when the stage holds no valid entry.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream offers {in_Instr, in_Addr}.
- in_ready  out  1  stage can accept an entry.
- in_Instr  in  INSTR_W  incoming instruction.
- in_Addr  in  ADDR_W  incoming address (PC+4).
- hold  in  1  stall: no accept, no consume.
- Flush  in  1  squash all held entries.
- out_valid  out  1  out_Instr/out_Addr carry a valid entry.
- out_ready  in  1  decode consumes the output entry.
- out_Instr  out  INSTR_W  head-entry instruction, BUBBLE_INSTR when empty.
- out_Addr  out  ADDR_W  head-entry address, 0 when empty.
- occupancy  out  2  number of entries held (0..2).

Behaviour:
- Storage: head register (drives outputs) and skid register. All outputs are registered or decoded from the state register only; there is no combinational path from in_valid or out_ready to any output.
- accept = in_valid & in_ready & ~hold & ~Flush.
- consume = out_valid & out_ready & ~hold & ~Flush.
- States (encoded as occupancy):
  - EMPTY (0): out_valid=0, in_ready=1.
  - ONE (1): out_valid=1, in_ready=1.
  - FULL (2): out_valid=1, in_ready=0.
- Transitions at the rising edge of clk:
  - EMPTY: accept -> ONE, head<=in. Otherwise stay.
  - ONE: accept & consume -> ONE, head<=in. accept & ~consume -> FULL, skid<=in. ~accept & consume -> EMPTY, head<=bubble. Otherwise stay, head unchanged.
  - FULL: accept is impossible (in_ready=0). consume -> ONE, head<=skid. Otherwise stay.
- bubble means Instr=BUBBLE_INSTR, Addr=0.
- Latency: an entry accepted at edge N appears on the outputs after edge N when the stage was EMPTY, or when ONE with a simultaneous consume. Otherwise it waits in skid.
- Throughput: one entry per cycle sustained when out_ready=1.
- Ordering: strict FIFO. Skid contents always move to head before any newer entry.
- hold=1: state, head and skid are unchanged regardless of in_valid/out_ready. in_ready and out_valid still reflect state, but no transfer occurs. Upstream must treat an offer during hold as not taken.
- Flush=1: next state EMPTY, head<=bubble, skid contents discarded. Any in_valid in the same cycle is dropped. Flush has priority over hold.
- reset (asynchronous, any time including mid-transfer): state=EMPTY, out_valid=0, in_ready=1, out_Instr=BUBBLE_INSTR, out_Addr=0, occupancy=0. The skid register may be cleared or left unchanged; it is unobservable.
- Data stability: out_Instr/out_Addr are stable while out_valid=1 and the entry has not been consumed.

Test Plan:
- Assert reset mid-stream in FULL -> same cycle: out_valid=0, in_ready=1, occupancy=0, out_Instr=BUBBLE_INSTR, out_Addr=0; after release, the first accept appears one cycle later.
- Stream 0x11111111, 0x22222222, 0x33333333 (Addr 4, 8, 12) with out_ready=1 -> each appears on out_* exactly one cycle after acceptance, in order, with in_ready=1 throughout.
- out_ready=0, offer 0xA0 then 0xB0 -> occupancy 1 then 2, in_ready=0. Third offer 0xC0 is held upstream. Raise out_ready -> outputs read 0xA0, 0xB0, 0xC0 in consecutive cycles, with no loss or duplication.
- State ONE with head 0xA0, then hold=1 for 3 cycles with in_valid=1 and out_ready=1 -> out_Instr stays 0xA0, occupancy stays 1, nothing is accepted. Release hold -> normal flow resumes.
- State FULL, then Flush=1 together with in_valid=1 (in_ready=0) and also hold=1 -> next cycle: occupancy=0, out_valid=0, out_Instr=BUBBLE_INSTR, out_Addr=0, and the offered entry does not appear later.
- State ONE with accept and consume in the same cycle -> occupancy stays 1 and head takes the new entry.

Source files
------------

// File: rtl/if_id_elastic.sv
// -----------------------------------------------------------------------------
// if_id_elastic
//
// Elastic IF/ID pipeline stage. Carries {instr, addr} pairs from fetch to
// decode with a valid/ready handshake on both sides. A head register drives
// the outputs and a skid register absorbs one extra entry, so upstream can
// keep running at full rate while downstream applies backpressure.
// hold freezes the stage and Flush squashes everything it holds.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   upstream offers {in_Instr, in_Addr}
//   in_ready   stage can take an entry (state is not FULL)
//   in_Instr   incoming instruction
//   in_Addr    incoming address (PC+4)
//   hold       stall: no accept, no consume
//   Flush      squash all held entries; takes priority over hold
//   out_valid  out_Instr/out_Addr carry a valid entry
//   out_ready  decode consumes the output entry
//   out_Instr  head instruction, BUBBLE_INSTR when empty
//   out_Addr   head address, 0 when empty
//   occupancy  number of entries held (0..2)
//
// Every output comes straight from a flop or from decoding the state
// register, so there is no combinational path from in_valid or out_ready to
// any output.
// -----------------------------------------------------------------------------
module if_id_elastic #(
    parameter int                   INSTR_W      = 32,
    parameter int                   ADDR_W       = 32,
    parameter logic [INSTR_W-1:0]   BUBBLE_INSTR = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  in_Instr,
    input  logic [ADDR_W-1:0]   in_Addr,
    input  logic                hold,
    input  logic                Flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_Instr,
    output logic [ADDR_W-1:0]   out_Addr,
    output logic [1:0]          occupancy
);

    // The state encoding is the occupancy count itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   head_instr_q, head_instr_d;
    logic [ADDR_W-1:0]    head_addr_q,  head_addr_d;
    logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]    skid_addr_q,  skid_addr_d;

    logic accept;
    logic consume;

    // Handshake flags decoded from state only.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign occupancy = state_q;
    assign out_Instr = head_instr_q;
    assign out_Addr  = head_addr_q;

    assign accept  = in_valid  & in_ready  & ~hold & ~Flush;
    assign consume = out_valid & out_ready & ~hold & ~Flush;

    always_comb begin
        state_d      = state_q;
        head_instr_d = head_instr_q;
        head_addr_d  = head_addr_q;
        skid_instr_d = skid_instr_q;
        skid_addr_d  = skid_addr_q;

        if (Flush) begin
            // Skid contents are simply abandoned; they are unreachable once
            // the state says EMPTY.
            state_d      = EMPTY;
            head_instr_d = BUBBLE_INSTR;
            head_addr_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d      = ONE;
                        head_instr_d = in_Instr;
                        head_addr_d  = in_Addr;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        head_instr_d = in_Instr;
                        head_addr_d  = in_Addr;
                    end else if (accept) begin
                        state_d      = FULL;
                        skid_instr_d = in_Instr;
                        skid_addr_d  = in_Addr;
                    end else if (consume) begin
                        // Head goes back to the bubble so the outputs read
                        // BUBBLE_INSTR/0 whenever the stage is empty.
                        state_d      = EMPTY;
                        head_instr_d = BUBBLE_INSTR;
                        head_addr_d  = '0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a consume can happen;
                    // the older skid entry moves up before anything newer.
                    if (consume) begin
                        state_d      = ONE;
                        head_instr_d = skid_instr_q;
                        head_addr_d  = skid_addr_q;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty stage.
                    state_d      = EMPTY;
                    head_instr_d = BUBBLE_INSTR;
                    head_addr_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            head_instr_q <= BUBBLE_INSTR;
            head_addr_q  <= '0;
            skid_instr_q <= '0;
            skid_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            head_instr_q <= head_instr_d;
            head_addr_q  <= head_addr_d;
            skid_instr_q <= skid_instr_d;
            skid_addr_q  <= skid_addr_d;
        end
    end

endmodule

// File: tb/tb_if_id_elastic.sv
// -----------------------------------------------------------------------------
// tb_if_id_elastic
//
// Directed bench for if_id_elastic. Each scenario lives in its own task that
// drives the inputs and compares outputs against hand-computed values.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// A non-zero bubble value is used so the bubble is distinguishable from zero.
// -----------------------------------------------------------------------------
module tb_if_id_elastic;

    localparam int          IW  = 32;
    localparam int          AW  = 32;
    localparam logic [31:0] BUB = 32'h0000_0013;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_Instr;
    logic [AW-1:0] in_Addr;
    logic          hold;
    logic          Flush;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_Instr;
    logic [AW-1:0] out_Addr;
    logic [1:0]    occupancy;

    int tests_run;
    int tests_failed;

    if_id_elastic #(
        .INSTR_W      (IW),
        .ADDR_W       (AW),
        .BUBBLE_INSTR (BUB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_Instr  (in_Instr),
        .in_Addr   (in_Addr),
        .hold      (hold),
        .Flush     (Flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_Instr (out_Instr),
        .out_Addr  (out_Addr),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] instr, input logic [31:0] addr);
        in_valid = v;
        in_Instr = instr;
        in_Addr  = addr;
    endtask

    // Reset values, then asynchronous reset in the middle of a FULL stream.
    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        tests_run++; if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        tests_run++; if (out_Instr !== BUB) begin tests_failed++; $display("FAIL reset_out_instr got %h want %h", out_Instr, BUB); end
        tests_run++; if (out_Addr !== 32'h0) begin tests_failed++; $display("FAIL reset_out_addr got %h want 0", out_Addr); end

        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b0;
        offer(1'b1, 32'h0000_00A1, 32'h4);
        step();
        offer(1'b1, 32'h0000_00A2, 32'h8);
        step();
        offer(1'b0, 32'h0, 32'h0);
        tests_run++; if (occupancy !== 2'd2) begin tests_failed++; $display("FAIL prereset_full got %0d want 2", occupancy); end

        // Mid-cycle, away from any edge: reset must act immediately.
        #2;
        reset = 1'b1;
        #1;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL async_out_valid got %0b want 0", out_valid); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL async_in_ready got %0b want 1", in_ready); end
        tests_run++; if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL async_occupancy got %0d want 0", occupancy); end
        tests_run++; if (out_Instr !== BUB) begin tests_failed++; $display("FAIL async_out_instr got %h want %h", out_Instr, BUB); end
        tests_run++; if (out_Addr !== 32'h0) begin tests_failed++; $display("FAIL async_out_addr got %h want 0", out_Addr); end

        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        offer(1'b1, 32'h0000_0055, 32'h40);
        step();
        offer(1'b0, 32'h0, 32'h0);
        $display("[TB] post-reset accept instr=%h addr=%h", out_Instr, out_Addr);
        tests_run++; if (out_valid !== 1'b1 || out_Instr !== 32'h55 || out_Addr !== 32'h40) begin tests_failed++; $display("FAIL postreset_first got v=%0b %h/%h want 1 00000055/00000040", out_valid, out_Instr, out_Addr); end
        step();
        tests_run++; if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL postreset_drain got %0d want 0", occupancy); end
    endtask

    // Full-rate stream with downstream always ready.
    task automatic test_stream();
        logic [31:0] instrs [3];
        instrs[0] = 32'h1111_1111;
        instrs[1] = 32'h2222_2222;
        instrs[2] = 32'h3333_3333;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, instrs[i], 32'(4 * (i + 1)));
            tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_in_ready[%0d] got %0b want 1", i, in_ready); end
            step();
            $display("[TB] stream out instr=%h addr=%h occ=%0d", out_Instr, out_Addr, occupancy);
            tests_run++; if (out_valid !== 1'b1 || out_Instr !== instrs[i] || out_Addr !== 32'(4 * (i + 1)) || occupancy !== 2'd1) begin
                tests_failed++;
                $display("FAIL stream_out[%0d] got v=%0b %h/%h occ=%0d want 1 %h/%h occ=1", i, out_valid, out_Instr, out_Addr, occupancy, instrs[i], 32'(4 * (i + 1)));
            end
        end
        offer(1'b0, 32'h0, 32'h0);
        step();
        tests_run++; if (occupancy !== 2'd0 || out_Instr !== BUB) begin tests_failed++; $display("FAIL stream_drain got occ=%0d instr=%h want 0 %h", occupancy, out_Instr, BUB); end
    endtask

    // Backpressure fills the skid; draining preserves order with no loss.
    task automatic test_backpressure();
        out_ready = 1'b0;
        offer(1'b1, 32'hA0, 32'h100);
        step();
        tests_run++; if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_Instr !== 32'hA0) begin tests_failed++; $display("FAIL bp_one got occ=%0d rdy=%0b instr=%h want 1 1 a0", occupancy, in_ready, out_Instr); end
        offer(1'b1, 32'hB0, 32'h104);
        step();
        tests_run++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_Instr !== 32'hA0) begin tests_failed++; $display("FAIL bp_full got occ=%0d rdy=%0b instr=%h want 2 0 a0", occupancy, in_ready, out_Instr); end
        offer(1'b1, 32'hC0, 32'h108);
        step();
        tests_run++; if (occupancy !== 2'd2 || out_Instr !== 32'hA0 || out_Addr !== 32'h100) begin tests_failed++; $display("FAIL bp_stall got occ=%0d %h/%h want 2 a0/100", occupancy, out_Instr, out_Addr); end
        out_ready = 1'b1;
        step();
        tests_run++; if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_Instr !== 32'hB0 || out_Addr !== 32'h104) begin tests_failed++; $display("FAIL bp_drain_b got occ=%0d rdy=%0b %h/%h want 1 1 b0/104", occupancy, in_ready, out_Instr, out_Addr); end
        step();
        offer(1'b0, 32'h0, 32'h0);
        tests_run++; if (occupancy !== 2'd1 || out_Instr !== 32'hC0 || out_Addr !== 32'h108) begin tests_failed++; $display("FAIL bp_drain_c got occ=%0d %h/%h want 1 c0/108", occupancy, out_Instr, out_Addr); end
        step();
        tests_run++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_Instr !== BUB) begin tests_failed++; $display("FAIL bp_empty got occ=%0d v=%0b instr=%h want 0 0 %h", occupancy, out_valid, out_Instr, BUB); end
    endtask

    // hold freezes the stage despite in_valid and out_ready.
    task automatic test_hold();
        out_ready = 1'b0;
        offer(1'b1, 32'hA0, 32'h200);
        step();
        hold = 1'b1;
        out_ready = 1'b1;
        offer(1'b1, 32'hD0, 32'h204);
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++; if (occupancy !== 2'd1 || out_valid !== 1'b1 || in_ready !== 1'b1 || out_Instr !== 32'hA0) begin
                tests_failed++;
                $display("FAIL hold_cycle[%0d] got occ=%0d v=%0b rdy=%0b instr=%h want 1 1 1 a0", i, occupancy, out_valid, in_ready, out_Instr);
            end
        end
        hold = 1'b0;
        step();
        offer(1'b0, 32'h0, 32'h0);
        tests_run++; if (occupancy !== 2'd1 || out_Instr !== 32'hD0 || out_Addr !== 32'h204) begin tests_failed++; $display("FAIL hold_resume got occ=%0d %h/%h want 1 d0/204", occupancy, out_Instr, out_Addr); end
        step();
        tests_run++; if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL hold_drain got %0d want 0", occupancy); end
    endtask

    // Flush from FULL beats hold and drops the concurrent offer.
    task automatic test_flush();
        out_ready = 1'b0;
        offer(1'b1, 32'hE0, 32'h300);
        step();
        offer(1'b1, 32'hE1, 32'h304);
        step();
        tests_run++; if (occupancy !== 2'd2) begin tests_failed++; $display("FAIL flush_prefull got %0d want 2", occupancy); end
        Flush = 1'b1;
        hold = 1'b1;
        out_ready = 1'b1;
        offer(1'b1, 32'hE2, 32'h308);
        step();
        Flush = 1'b0;
        hold = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        tests_run++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_Instr !== BUB || out_Addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL flush_empty got occ=%0d v=%0b %h/%h want 0 0 %h/0", occupancy, out_valid, out_Instr, out_Addr, BUB);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            tests_run++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin tests_failed++; $display("FAIL flush_stays_empty[%0d] got v=%0b occ=%0d want 0 0", i, out_valid, occupancy); end
        end
    endtask

    // In ONE, accept and consume together replace the head in place.
    task automatic test_accept_consume();
        out_ready = 1'b0;
        offer(1'b1, 32'hF0, 32'h400);
        step();
        out_ready = 1'b1;
        offer(1'b1, 32'hF1, 32'h404);
        step();
        offer(1'b0, 32'h0, 32'h0);
        tests_run++; if (occupancy !== 2'd1 || out_Instr !== 32'hF1 || out_Addr !== 32'h404) begin tests_failed++; $display("FAIL ac_replace got occ=%0d %h/%h want 1 f1/404", occupancy, out_Instr, out_Addr); end
        step();
        tests_run++; if (occupancy !== 2'd0 || out_Instr !== BUB) begin tests_failed++; $display("FAIL ac_drain got occ=%0d instr=%h want 0 %h", occupancy, out_Instr, BUB); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_Instr  = '0;
        in_Addr   = '0;
        hold      = 1'b0;
        Flush     = 1'b0;
        out_ready = 1'b0;

        test_reset();
        test_stream();
        test_backpressure();
        test_hold();
        test_flush();
        test_accept_consume();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
